// File: rtl/cycle_timer_pkg.sv
// cycle_timer shared types and default constants.
// Imported by the cycle_timer top and its per-channel sub-module.
package cycle_timer_pkg;

   typedef enum logic {
      IDLE = 1'b0,
      RUN  = 1'b1
   } ch_state_e;

   localparam int DEF_NUM_CH     = 4;
   localparam int DEF_CNT_W      = 16;
   localparam int DEF_FINISH_CYC = 10;
   localparam int DEF_PRESCALE   = 4;
   localparam int CYC_W          = 32;

endpackage

// File: rtl/cycle_timer_ch.sv
// One timer channel: IDLE/RUN FSM, down-counter, reload value and mode.
// Counts on i_tick; o_expire is a registered single-cycle pulse.
module cycle_timer_ch
   import cycle_timer_pkg::*;
#(
   parameter int CNT_W = DEF_CNT_W
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             i_tick,
   input  logic             i_start,
   input  logic             i_stop,
   input  logic             i_periodic,
   input  logic [CNT_W-1:0] i_load,
   output logic             o_busy,
   output logic             o_expire
);

   ch_state_e        r_state;
   ch_state_e        w_nx_state;
   logic [CNT_W-1:0] r_cnt;
   logic [CNT_W-1:0] w_nx_cnt;
   logic [CNT_W-1:0] r_rld;
   logic [CNT_W-1:0] w_nx_rld;
   logic             r_per;
   logic             w_nx_per;
   logic             r_exp;
   logic             w_nx_exp;
   logic             w_load_ok;

   assign w_load_ok = i_start && (i_load != '0);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= IDLE;
         r_cnt   <= '0;
         r_rld   <= '0;
         r_per   <= 1'b0;
         r_exp   <= 1'b0;
      end else begin
         r_state <= w_nx_state;
         r_cnt   <= w_nx_cnt;
         r_rld   <= w_nx_rld;
         r_per   <= w_nx_per;
         r_exp   <= w_nx_exp;
      end
   end

   // stop beats start; a restart swallows any expiry due this cycle
   always_comb begin
      w_nx_state = r_state;
      w_nx_cnt   = r_cnt;
      w_nx_rld   = r_rld;
      w_nx_per   = r_per;
      w_nx_exp   = 1'b0;
      unique case (r_state)
         IDLE: begin
            if (!i_stop && w_load_ok) begin
               w_nx_state = RUN;
               w_nx_cnt   = i_load;
               w_nx_rld   = i_load;
               w_nx_per   = i_periodic;
            end
         end
         RUN: begin
            if (i_stop) begin
               w_nx_state = IDLE;
               w_nx_cnt   = '0;
            end else if (w_load_ok) begin
               w_nx_cnt = i_load;
               w_nx_rld = i_load;
               w_nx_per = i_periodic;
            end else if (i_tick) begin
               if (r_cnt == CNT_W'(1)) begin
                  w_nx_exp = 1'b1;
                  if (r_per) begin
                     w_nx_cnt = r_rld;
                  end else begin
                     w_nx_state = IDLE;
                     w_nx_cnt   = '0;
                  end
               end else begin
                  w_nx_cnt = r_cnt - CNT_W'(1);
               end
            end
         end
      endcase
   end

   assign o_busy   = (r_state == RUN);
   assign o_expire = r_exp;

endmodule

// File: rtl/cycle_timer.sv
// cycle_timer top: NUM_CH timer channels, free-running cycle counter, finish flag.
// Define CYCLE_TIMER_PRESCALE_EN to divide the channel tick by PRESCALE.
module cycle_timer
   import cycle_timer_pkg::*;
#(
   parameter int NUM_CH     = DEF_NUM_CH,
   parameter int CNT_W      = DEF_CNT_W,
   parameter int FINISH_CYC = DEF_FINISH_CYC,
   parameter int PRESCALE   = DEF_PRESCALE
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic [NUM_CH-1:0]       start,
   input  logic [NUM_CH-1:0]       stop,
   input  logic [NUM_CH-1:0]       periodic,
   input  logic [NUM_CH*CNT_W-1:0] load_val,
   output logic [NUM_CH-1:0]       busy,
   output logic [NUM_CH-1:0]       expire,
   output logic [CYC_W-1:0]        cyc_count,
   output logic                    finish
);

   logic             w_tick;
   logic [CYC_W-1:0] r_cyc;
   logic             r_fin;

`ifdef CYCLE_TIMER_PRESCALE_EN
   localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

   logic [PW-1:0] r_pre;
   logic          w_pre_wrap;

   assign w_pre_wrap = (r_pre == PW'(PRESCALE - 1));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_pre <= '0;
      end else if (w_pre_wrap) begin
         r_pre <= '0;
      end else begin
         r_pre <= r_pre + PW'(1);
      end
   end

   assign w_tick = w_pre_wrap;
`else
   logic w_unused_prescale;

   // divisor has no meaning without the prescaler
   assign w_unused_prescale = PRESCALE[0];
   assign w_tick            = 1'b1;
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_cyc <= '0;
         r_fin <= 1'b0;
      end else begin
         if (r_cyc != '1) begin
            r_cyc <= r_cyc + CYC_W'(1);
         end
         if (r_cyc == CYC_W'(FINISH_CYC)) begin
            r_fin <= 1'b1;
         end
      end
   end

   assign cyc_count = r_cyc;
   assign finish    = r_fin;

   for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
      cycle_timer_ch #(
         .CNT_W(CNT_W)
      ) u_ch (
         .clk        (clk),
         .rst_n      (rst_n),
         .i_tick     (w_tick),
         .i_start    (start[g]),
         .i_stop     (stop[g]),
         .i_periodic (periodic[g]),
         .i_load     (load_val[g*CNT_W +: CNT_W]),
         .o_busy     (busy[g]),
         .o_expire   (expire[g])
      );
   end

endmodule

// File: tb/tb_cycle_timer.sv
// Directed, table-driven bench for cycle_timer (default build, tick every cycle).
module tb_cycle_timer;

   localparam int NCH = 4;
   localparam int CW  = 16;

   logic              clk;
   logic              rst_n;
   logic [NCH-1:0]    start;
   logic [NCH-1:0]    stop;
   logic [NCH-1:0]    periodic;
   logic [NCH*CW-1:0] load_val;
   logic [NCH-1:0]    busy;
   logic [NCH-1:0]    expire;
   logic [31:0]       cyc_count;
   logic              finish;

   int total;
   int bad;

   cycle_timer #(
      .NUM_CH     (NCH),
      .CNT_W      (CW),
      .FINISH_CYC (10),
      .PRESCALE   (4)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .start     (start),
      .stop      (stop),
      .periodic  (periodic),
      .load_val  (load_val),
      .busy      (busy),
      .expire    (expire),
      .cyc_count (cyc_count),
      .finish    (finish)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [3:0]  st;
      logic [3:0]  sp;
      logic [3:0]  per;
      logic [15:0] ld0;
      logic [15:0] ld1;
      logic [3:0]  busy;
      logic [3:0]  exp;
   } vec_t;

   vec_t tv[34];

   task automatic chk(input string name, input logic [31:0] act,
                      input logic [31:0] req);
      total++;
      if (act !== req) begin
         bad++;
         $display("FAIL %s: got %0h want %0h", name, act, req);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input vec_t v);
      start    = v.st;
      stop     = v.sp;
      periodic = v.per;
      load_val = '0;
      load_val[0*CW +: CW] = v.ld0;
      load_val[1*CW +: CW] = v.ld1;
   endtask

   initial begin
      total = 0;
      bad   = 0;
      // one-shot ch0, N=5
      tv[0]  = '{4'b0001, 4'b0000, 4'b0000, 16'd5, 16'd0, 4'b0001, 4'b0000};
      tv[1]  = '{4'b0000, 4'b0000, 4'b0000, 16'd0, 16'd0, 4'b0001, 4'b0000};
      tv[2]  = '{4'b0000, 4'b0000, 4'b0000, 16'd0, 16'd0, 4'b0001, 4'b0000};
      tv[3]  = '{4'b0000, 4'b0000, 4'b0000, 16'd0, 16'd0, 4'b0001, 4'b0000};
      tv[4]  = '{4'b0000, 4'b0000, 4'b0000, 16'd0, 16'd0, 4'b0001, 4'b0000};
      tv[5]  = '{4'b0000, 4'b0000, 4'b0000, 16'd0, 16'd0, 4'b0000, 4'b0001};
      tv[6]  = '{4'b0000, 4'b0000, 4'b0000, 16'd0, 16'd0, 4'b0000, 4'b0000};
      // periodic ch1, N=3, stop at +7
      tv[7]  = '{4'b0010, 4'b0000, 4'b0010, 16'd0, 16'd3, 4'b0010, 4'b0000};
      tv[8]  = '{4'b0000, 4'b0000, 4'b0000, 16'd0, 16'd0, 4'b0010, 4'b0000};
      tv[9]  = '{4'b0000, 4'b0000, 4'b0000, 16'd0, 16'd0, 4'b0010, 4'b0000};
      tv[10] = '{4'b0000, 4'b0000, 4'b0000, 16'd0, 16'd0, 4'b0010, 4'b0010};
      tv[11] = '{4'b0000, 4'b0000, 4'b0000, 16'd0, 16'd0, 4'b0010, 4'b0000};
      tv[12] = '{4'b0000, 4'b0000, 4'b0000, 16'd0, 16'd0, 4'b0010, 4'b0000};
      tv[13] = '{4'b0000, 4'b0000, 4'b0000, 16'd0, 16'd0, 4'b0010, 4'b0010};
      tv[14] = '{4'b0000, 4'b0010, 4'b0000, 16'd0, 16'd0, 4'b0000, 4'b0000};
      tv[15] = '{4'b0000, 4'b0000, 4'b0000, 16'd0, 16'd0, 4'b0000, 4'b0000};
      tv[16] = '{4'b0000, 4'b0000, 4'b0000, 16'd0, 16'd0, 4'b0000, 4'b0000};
      // zero-load start ignored, stop in IDLE harmless
      tv[17] = '{4'b0001, 4'b0000, 4'b0000, 16'd0, 16'd0, 4'b0000, 4'b0000};
      tv[18] = '{4'b0000, 4'b0001, 4'b0000, 16'd0, 16'd0, 4'b0000, 4'b0000};
      // start+stop in RUN -> IDLE
      tv[19] = '{4'b0001, 4'b0000, 4'b0000, 16'd9, 16'd0, 4'b0001, 4'b0000};
      tv[20] = '{4'b0001, 4'b0001, 4'b0000, 16'd9, 16'd0, 4'b0000, 4'b0000};
      // restart at cnt=1 with load 4
      tv[21] = '{4'b0001, 4'b0000, 4'b0000, 16'd3, 16'd0, 4'b0001, 4'b0000};
      tv[22] = '{4'b0000, 4'b0000, 4'b0000, 16'd0, 16'd0, 4'b0001, 4'b0000};
      tv[23] = '{4'b0000, 4'b0000, 4'b0000, 16'd0, 16'd0, 4'b0001, 4'b0000};
      tv[24] = '{4'b0001, 4'b0000, 4'b0000, 16'd4, 16'd0, 4'b0001, 4'b0000};
      tv[25] = '{4'b0000, 4'b0000, 4'b0000, 16'd0, 16'd0, 4'b0001, 4'b0000};
      tv[26] = '{4'b0000, 4'b0000, 4'b0000, 16'd0, 16'd0, 4'b0001, 4'b0000};
      tv[27] = '{4'b0000, 4'b0000, 4'b0000, 16'd0, 16'd0, 4'b0001, 4'b0000};
      tv[28] = '{4'b0000, 4'b0000, 4'b0000, 16'd0, 16'd0, 4'b0000, 4'b0001};
      // two channels together, independent modes
      tv[29] = '{4'b0011, 4'b0000, 4'b0010, 16'd2, 16'd2, 4'b0011, 4'b0000};
      tv[30] = '{4'b0000, 4'b0000, 4'b0000, 16'd0, 16'd0, 4'b0011, 4'b0000};
      tv[31] = '{4'b0000, 4'b0000, 4'b0000, 16'd0, 16'd0, 4'b0010, 4'b0011};
      tv[32] = '{4'b0000, 4'b0010, 4'b0000, 16'd0, 16'd0, 4'b0000, 4'b0000};
      tv[33] = '{4'b0000, 4'b0000, 4'b0000, 16'd0, 16'd0, 4'b0000, 4'b0000};

      rst_n    = 1'b0;
      start    = '0;
      stop     = '0;
      periodic = '0;
      load_val = '0;
      #1;
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_exp", 32'(expire), 32'd0);
      chk("rst_cyc", cyc_count, 32'd0);
      chk("rst_fin", 32'(finish), 32'd0);
      repeat (2) step();
      chk("rst_hold_cyc", cyc_count, 32'd0);
      rst_n = 1'b1;

      for (int k = 1; k <= 14; k++) begin
         step();
         chk($sformatf("cyc_%0d", k), cyc_count, 32'(k));
         chk($sformatf("fin_%0d", k), 32'(finish), (k >= 11) ? 32'd1 : 32'd0);
      end

      for (int i = 0; i < 34; i++) begin
         drive(tv[i]);
         step();
         chk($sformatf("v%0d_busy", i), 32'(busy), 32'(tv[i].busy));
         chk($sformatf("v%0d_exp", i), 32'(expire), 32'(tv[i].exp));
      end
      chk("fin_sticky", 32'(finish), 32'd1);

      // reset mid-count
      drive('{4'b0001, 4'b0000, 4'b0000, 16'd5, 16'd0, 4'b0000, 4'b0000});
      step();
      drive('{4'b0000, 4'b0000, 4'b0000, 16'd0, 16'd0, 4'b0000, 4'b0000});
      step();
      chk("pre_rst_busy", 32'(busy), 32'd1);
      rst_n = 1'b0;
      #1;
      chk("mid_rst_busy", 32'(busy), 32'd0);
      chk("mid_rst_cyc", cyc_count, 32'd0);
      chk("mid_rst_fin", 32'(finish), 32'd0);
      rst_n = 1'b1;
      for (int k = 1; k <= 8; k++) begin
         step();
         chk($sformatf("post_rst_exp_%0d", k), 32'(expire), 32'd0);
         chk($sformatf("post_rst_busy_%0d", k), 32'(busy), 32'd0);
         chk($sformatf("post_rst_cyc_%0d", k), cyc_count, 32'(k));
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
